drop_sequencer: RTL and testbench
=================================

Name: drop_sequencer

Overview:
- Game-level sequencer for the falling-image controller.
- Arms a drop on a mouse click and latches a clamped start position. Holds the fall controller's enable high until it reports landing, then enforces a cooldown.
- Counts remaining drops per round and flags game over.
- Sits between the mouse decoder and the fall controller in the 800x600 VGA pipeline.

Parameters:
- MAX_DROPS, 9: drops per round (1..15).
- X_LIMIT, 736: max legal start x (800 - 64 image width).
- Y_LIMIT, 536: clicks with ypos >= Y_LIMIT are rejected (600 - 64).
- COOLDOWN_CYCLES, 4_000_000: post-landing lockout, 100 ms at 40 MHz.
- TIMEOUT_CYCLES, 200_000_000: fall watchdog, 5 s at 40 MHz.
- BLANK_CYCLES, 4: cycles after entering FALL during which fall_finish is ignored.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- start_game  in  1  single-cycle pulse to start a round
- mouse_left  in  1  left button level, already synchronous to clk
- mouse_xpos  in  12  cursor x
- mouse_ypos  in  12  cursor y
- fall_finish  in  1  landing flag from the fall controller (level)
- fall_on  out  1  enable to the fall controller
- drop_xpos  out  12  latched start x
- drop_ypos  out  12  latched start y
- drops_left  out  4  remaining drops
- drop_done  out  1  one-cycle pulse per completed drop
- timeout_flag  out  1  sticky: last drop ended by watchdog
- busy  out  1  high in FALL, LAND, COOL
- game_over  out  1  high in OVER

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, timer cleared, click edge register 0.
- All outputs are registered.
- Click detect: click = mouse_left & ~mouse_left_q. mouse_left_q updates every cycle in every state.
- IDLE:
  - start_game -> ARMED; drops_left <= MAX_DROPS; timeout_flag <= 0.
- ARMED:
  - Click with mouse_ypos < Y_LIMIT -> FALL.
  - On that transition: drop_xpos <= min(mouse_xpos, X_LIMIT); drop_ypos <= mouse_ypos; timer loaded.
  - Clicks with mouse_ypos >= Y_LIMIT are ignored; stay in ARMED.
- FALL:
  - fall_on = 1. fall_on rises the cycle after the accepting click.
  - fall_finish is ignored for the first BLANK_CYCLES cycles; this masks a stale finish left over from the previous drop.
  - After blanking, fall_finish = 1 -> LAND; timeout_flag <= 0.
  - Timer reaches TIMEOUT_CYCLES -> LAND; timeout_flag <= 1.
  - If finish and timeout occur in the same cycle, finish wins and timeout_flag <= 0.
- LAND (exactly 1 cycle):
  - fall_on = 0; drop_done = 1; drops_left <= drops_left - 1.
  - If drops_left was 1 -> OVER, else -> COOL with timer loaded.
- COOL:
  - Clicks are ignored.
  - After COOLDOWN_CYCLES cycles -> ARMED.
  - A click on the exit cycle is not accepted.
- OVER:
  - game_over = 1.
  - start_game -> ARMED; reload drops_left; game_over <= 0.
- start_game is ignored in ARMED, FALL, LAND and COOL.
- Position changes are ignored outside the ARMED accept cycle.
- drops_left never wraps below 0.
- Timer: 28-bit up-counter with synchronous load. done is asserted when count == limit - 1, so a state lasts exactly limit cycles.
- Reset asserted mid-FALL drops fall_on immediately (asynchronous).

Decomposition:
- Shared package game_pkg:
  - state enum: IDLE, ARMED, FALL, LAND, COOL, OVER.
  - Screen constants H_ACTIVE=800, V_ACTIVE=600, IMG_SIZE=64.
  - X_LIMIT and Y_LIMIT derived from those constants.
- One sub-module, cycle_timer (load, limit[27:0], done).
- cycle_timer is shared by the FALL watchdog and COOL.

Test Plan (MAX_DROPS=2, COOLDOWN_CYCLES=8, TIMEOUT_CYCLES=50, BLANK_CYCLES=4):
1. Reset, then start_game -> drops_left=2, state ARMED. Click at (100,200) -> next cycle fall_on=1, drop_xpos=100, drop_ypos=200.
2. Click at (790,300) -> drop_xpos=736. Click at (50,540) -> ignored: fall_on stays 0, drops_left stays 2.
3. In FALL, hold fall_finish=1 for cycles 1-4 -> ignored. Keep it high into cycle 5 -> LAND: drop_done pulses, drops_left=1, fall_on=0.
4. Click during COOL -> ignored. Click 8 cycles after LAND -> accepted.
5. Never assert fall_finish -> LAND after 50 cycles, timeout_flag=1. Second drop completes -> game_over=1, drops_left=0. start_game -> drops_left=2, game_over=0.
6. Pull rst_n low mid-FALL -> fall_on=0 asynchronously, state IDLE. A click after reset with no start_game -> ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the falling-image game: sequencer states,
// screen geometry and the legal drop window derived from it.
package game_pkg;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned V_ACTIVE = 600;
   localparam int unsigned IMG_SIZE = 64;

   // Rightmost legal start x; clicks at or below Y_LIMIT would clip the image.
   localparam int unsigned X_LIMIT  = H_ACTIVE - IMG_SIZE;
   localparam int unsigned Y_LIMIT  = V_ACTIVE - IMG_SIZE;

   localparam int unsigned POS_W    = 12;
   localparam int unsigned DROPS_W  = 4;
   localparam int unsigned TIMER_W  = 28;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      FALL  = 3'd2,
      LAND  = 3'd3,
      COOL  = 3'd4,
      OVER  = 3'd5
   } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Free-running 28-bit up-counter with synchronous clear-on-load.
// done is high in the cycle where count == limit - 1, so a state that
// loads the timer on entry and leaves on done lasts exactly limit cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        restart counting from 0 next cycle
//   limit       terminal count (must stay stable while timing)
//   count       current count (registered)
//   done        count == limit - 1 (registered)
module cycle_timer
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [TIMER_W-1:0] limit,
   output logic [TIMER_W-1:0] count,
   output logic               done
);

   logic [TIMER_W-1:0] count_inc;

   assign count_inc = count + TIMER_W'(1);

   // done is precomputed from the next count so it lines up with count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         done  <= 1'b0;
      end else if (load) begin
         count <= '0;
         done  <= (limit == TIMER_W'(1));
      end else begin
         count <= count_inc;
         done  <= (count_inc == (limit - TIMER_W'(1)));
      end
   end

endmodule

// File: rtl/drop_sequencer.sv
// Game-level sequencer between the mouse decoder and the fall controller.
// Arms a drop on a click, latches a clamped start position, enables the
// fall controller until landing (or watchdog), then enforces a cooldown.
// Counts remaining drops per round and flags game over.
// Ports:
//   clk, rst_n     pixel clock, asynchronous active-low reset
//   start_game     one-cycle pulse starting a round (IDLE / OVER only)
//   mouse_left     left button level, synchronous to clk
//   mouse_xpos/ypos cursor position
//   fall_finish    landing level from the fall controller
//   fall_on        fall controller enable (high in FALL)
//   drop_xpos/ypos latched start position
//   drops_left     remaining drops in the round
//   drop_done      one-cycle pulse per completed drop
//   timeout_flag   last drop was ended by the watchdog
//   busy           high in FALL, LAND, COOL
//   game_over      high in OVER
module drop_sequencer
   import game_pkg::*;
#(
   parameter int unsigned MAX_DROPS       = 9,
   parameter int unsigned X_LIMIT         = game_pkg::X_LIMIT,
   parameter int unsigned Y_LIMIT         = game_pkg::Y_LIMIT,
   parameter int unsigned COOLDOWN_CYCLES = 4_000_000,
   parameter int unsigned TIMEOUT_CYCLES  = 200_000_000,
   parameter int unsigned BLANK_CYCLES    = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_game,
   input  logic               mouse_left,
   input  logic [POS_W-1:0]   mouse_xpos,
   input  logic [POS_W-1:0]   mouse_ypos,
   input  logic               fall_finish,
   output logic               fall_on,
   output logic [POS_W-1:0]   drop_xpos,
   output logic [POS_W-1:0]   drop_ypos,
   output logic [DROPS_W-1:0] drops_left,
   output logic               drop_done,
   output logic               timeout_flag,
   output logic               busy,
   output logic               game_over
);

   state_t               state, state_n;
   logic                 mouse_left_q;
   logic                 click;
   logic                 blanking;

   logic [POS_W-1:0]     xpos_n, ypos_n;
   logic [DROPS_W-1:0]   drops_n;
   logic                 tflag_n;
   logic                 fall_on_n, drop_done_n, busy_n, game_over_n;

   logic                 tmr_load;
   logic [TIMER_W-1:0]   tmr_limit;
   logic [TIMER_W-1:0]   tmr_count;
   logic                 tmr_done;

   assign click    = mouse_left & ~mouse_left_q;
   // Masks a finish level left over from the previous drop
   assign blanking = (tmr_count < TIMER_W'(BLANK_CYCLES));
   // One timer serves the FALL watchdog and the COOL lockout
   assign tmr_limit = ((state == LAND) || (state == COOL)) ? TIMER_W'(COOLDOWN_CYCLES)
                                                           : TIMER_W'(TIMEOUT_CYCLES);

   cycle_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .limit (tmr_limit),
      .count (tmr_count),
      .done  (tmr_done)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mouse_left_q <= 1'b0;
         drop_xpos    <= '0;
         drop_ypos    <= '0;
         drops_left   <= '0;
         timeout_flag <= 1'b0;
         fall_on      <= 1'b0;
         drop_done    <= 1'b0;
         busy         <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_n;
         mouse_left_q <= mouse_left;
         drop_xpos    <= xpos_n;
         drop_ypos    <= ypos_n;
         drops_left   <= drops_n;
         timeout_flag <= tflag_n;
         fall_on      <= fall_on_n;
         drop_done    <= drop_done_n;
         busy         <= busy_n;
         game_over    <= game_over_n;
      end
   end

   // Next state; outputs are decoded from the next state so they register
   // in step with it
   always_comb begin
      state_n  = state;
      xpos_n   = drop_xpos;
      ypos_n   = drop_ypos;
      drops_n  = drops_left;
      tflag_n  = timeout_flag;
      tmr_load = 1'b0;

      case (state)
         IDLE: begin
            if (start_game) begin
               state_n = ARMED;
               drops_n = DROPS_W'(MAX_DROPS);
               tflag_n = 1'b0;
            end
         end
         ARMED: begin
            if (click && (mouse_ypos < POS_W'(Y_LIMIT))) begin
               state_n  = FALL;
               xpos_n   = (mouse_xpos > POS_W'(X_LIMIT)) ? POS_W'(X_LIMIT) : mouse_xpos;
               ypos_n   = mouse_ypos;
               tmr_load = 1'b1;
            end
         end
         FALL: begin
            // A real landing beats a coincident watchdog expiry
            if (fall_finish && !blanking) begin
               state_n = LAND;
               tflag_n = 1'b0;
            end else if (tmr_done) begin
               state_n = LAND;
               tflag_n = 1'b1;
            end
         end
         LAND: begin
            if (drops_left != '0) begin
               drops_n = drops_left - DROPS_W'(1);
            end
            if (drops_left <= DROPS_W'(1)) begin
               state_n = OVER;
            end else begin
               state_n  = COOL;
               tmr_load = 1'b1;
            end
         end
         COOL: begin
            if (tmr_done) begin
               state_n = ARMED;
            end
         end
         OVER: begin
            if (start_game) begin
               state_n = ARMED;
               drops_n = DROPS_W'(MAX_DROPS);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      fall_on_n   = (state_n == FALL);
      drop_done_n = (state_n == LAND);
      busy_n      = (state_n == FALL) || (state_n == LAND) || (state_n == COOL);
      game_over_n = (state_n == OVER);
   end

endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer with a short round: 2 drops, 8-cycle cooldown,
// 50-cycle watchdog, 4-cycle finish blanking.
module tb_drop_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_game;
   logic        mouse_left;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        fall_finish;
   logic        fall_on;
   logic [11:0] drop_xpos;
   logic [11:0] drop_ypos;
   logic [3:0]  drops_left;
   logic        drop_done;
   logic        timeout_flag;
   logic        busy;
   logic        game_over;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic st;
      logic lf;
      int   x;
      int   y;
      logic fin;
      logic fo;
      logic dd;
      int   dl;
      logic bz;
      logic go;
      int   ex;
      int   ey;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   drop_sequencer #(
      .MAX_DROPS       (2),
      .X_LIMIT         (736),
      .Y_LIMIT         (536),
      .COOLDOWN_CYCLES (8),
      .TIMEOUT_CYCLES  (50),
      .BLANK_CYCLES    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_game   (start_game),
      .mouse_left   (mouse_left),
      .mouse_xpos   (mouse_xpos),
      .mouse_ypos   (mouse_ypos),
      .fall_finish  (fall_finish),
      .fall_on      (fall_on),
      .drop_xpos    (drop_xpos),
      .drop_ypos    (drop_ypos),
      .drops_left   (drops_left),
      .drop_done    (drop_done),
      .timeout_flag (timeout_flag),
      .busy         (busy),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic lf, input int x, input int y,
                      input logic fin, input logic fo, input logic dd, input int dl,
                      input logic bz, input logic go, input int ex, input int ey);
      vec_t v;
      v.st = st; v.lf = lf; v.x = x; v.y = y; v.fin = fin;
      v.fo = fo; v.dd = dd; v.dl = dl; v.bz = bz; v.go = go; v.ex = ex; v.ey = ey;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t e;
      rst_n       = 1'b0;
      start_game  = 1'b0;
      mouse_left  = 1'b0;
      mouse_xpos  = '0;
      mouse_ypos  = '0;
      fall_finish = 1'b0;

      //   st lf  x    y   fin fo dd dl bz go  ex   ey
      add(1, 0,   0,   0, 0,  0, 0, 2, 0, 0,   0,   0); // v0 start round
      add(0, 0,   0,   0, 0,  0, 0, 2, 0, 0,   0,   0); // v1
      add(0, 1,  50, 536, 0,  0, 0, 2, 0, 0,   0,   0); // v2 y == limit rejected
      add(0, 0,   0,   0, 0,  0, 0, 2, 0, 0,   0,   0); // v3
      add(1, 0,   0,   0, 0,  0, 0, 2, 0, 0,   0,   0); // v4 start ignored in ARMED
      add(0, 1, 100, 200, 0,  1, 0, 2, 1, 0, 100, 200); // v5 accepted click
      add(0, 1, 300,  10, 1,  1, 0, 2, 1, 0, 100, 200); // v6 FALL c1, finish blanked
      add(0, 0,   0,   0, 1,  1, 0, 2, 1, 0, 100, 200); // v7 c2
      add(0, 0,   0,   0, 1,  1, 0, 2, 1, 0, 100, 200); // v8 c3
      add(0, 0,   0,   0, 1,  1, 0, 2, 1, 0, 100, 200); // v9 c4
      add(0, 0,   0,   0, 1,  0, 1, 2, 1, 0, 100, 200); // v10 c5 -> LAND
      add(0, 0,   0,   0, 0,  0, 0, 1, 1, 0, 100, 200); // v11 COOL
      add(0, 1,  10,  10, 0,  0, 0, 1, 1, 0, 100, 200); // v12 click in COOL ignored
      for (int i = 0; i < 6; i++)
         add(0, 0,  0,   0, 0,  0, 0, 1, 1, 0, 100, 200); // v13..v18
      add(0, 1,  10,  10, 0,  0, 0, 1, 0, 0, 100, 200); // v19 click on exit cycle
      add(0, 0,   0,   0, 0,  0, 0, 1, 0, 0, 100, 200); // v20 ARMED
      add(0, 1, 790, 300, 0,  1, 0, 1, 1, 0, 736, 300); // v21 clamped x

      // Reset values
      repeat (2) @(negedge clk);
      check("rst.fall_on", int'(fall_on), 0);
      check("rst.drops_left", int'(drops_left), 0);
      check("rst.busy", int'(busy), 0);
      check("rst.game_over", int'(game_over), 0);
      check("rst.drop_xpos", int'(drop_xpos), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: drive at a negedge, check at the next one through the scoreboard
      for (int i = 0; i < vecs.size(); i++) begin
         start_game  = vecs[i].st;
         mouse_left  = vecs[i].lf;
         mouse_xpos  = 12'(vecs[i].x);
         mouse_ypos  = 12'(vecs[i].y);
         fall_finish = vecs[i].fin;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("v%0d.fall_on", i), int'(fall_on), int'(e.fo));
         check($sformatf("v%0d.drop_done", i), int'(drop_done), int'(e.dd));
         check($sformatf("v%0d.drops_left", i), int'(drops_left), e.dl);
         check($sformatf("v%0d.busy", i), int'(busy), int'(e.bz));
         check($sformatf("v%0d.game_over", i), int'(game_over), int'(e.go));
         check($sformatf("v%0d.drop_xpos", i), int'(drop_xpos), e.ex);
         check($sformatf("v%0d.drop_ypos", i), int'(drop_ypos), e.ey);
      end
      start_game  = 1'b0;
      mouse_left  = 1'b0;
      fall_finish = 1'b0;

      // Watchdog: no finish, FALL lasts 50 cycles, last drop -> OVER
      repeat (49) @(negedge clk);
      check("to.fall_on_c50", int'(fall_on), 1);
      check("to.flag_before", int'(timeout_flag), 0);
      @(negedge clk);
      check("to.drop_done", int'(drop_done), 1);
      check("to.fall_on", int'(fall_on), 0);
      check("to.flag", int'(timeout_flag), 1);
      @(negedge clk);
      check("over.game_over", int'(game_over), 1);
      check("over.drops_left", int'(drops_left), 0);
      check("over.busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      check("over.no_wrap", int'(drops_left), 0);
      check("over.hold", int'(game_over), 1);
      start_game = 1'b1;
      @(negedge clk);
      start_game = 1'b0;
      check("restart.drops_left", int'(drops_left), 2);
      check("restart.game_over", int'(game_over), 0);

      // Finish and watchdog on the same cycle: finish wins
      mouse_left = 1'b1; mouse_xpos = 12'd0; mouse_ypos = 12'd535;
      @(negedge clk);
      mouse_left = 1'b0;
      check("tie.fall_on", int'(fall_on), 1);
      check("tie.drop_ypos", int'(drop_ypos), 535);
      repeat (49) @(negedge clk);
      fall_finish = 1'b1;
      @(negedge clk);
      fall_finish = 1'b0;
      check("tie.drop_done", int'(drop_done), 1);
      check("tie.flag", int'(timeout_flag), 0);
      @(negedge clk);
      check("tie.drops_left", int'(drops_left), 1);
      check("tie.cool_busy", int'(busy), 1);

      // Asynchronous reset mid-FALL
      repeat (8) @(negedge clk);
      check("rf.armed_busy", int'(busy), 0);
      mouse_left = 1'b1; mouse_xpos = 12'd400; mouse_ypos = 12'd100;
      @(negedge clk);
      mouse_left = 1'b0;
      check("rf.fall_on", int'(fall_on), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rf.async_fall_on", int'(fall_on), 0);
      check("rf.async_busy", int'(busy), 0);
      check("rf.async_drops", int'(drops_left), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mouse_left = 1'b1;
      @(negedge clk);
      mouse_left = 1'b0;
      @(negedge clk);
      check("idle.click_fall_on", int'(fall_on), 0);
      check("idle.click_busy", int'(busy), 0);
      check("idle.drop_xpos", int'(drop_xpos), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
